// File: rtl/stream_demux_if.sv
// Handshake bundle between one producer, the demux, and N_CH consumers.
// The producer side uses master; the demux uses slave.
interface stream_demux_if #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = 2
);
    logic                   enable_i;
    logic                   broadcast_i;
    logic [SEL_W-1:0]       sel_i;
    logic [DATA_W-1:0]      data_i;
    logic                   valid_i;
    logic                   ready_o;
    logic [N_CH*DATA_W-1:0] data_o;
    logic [N_CH-1:0]        valid_o;
    logic [N_CH-1:0]        ready_i;
    logic                   sel_err_o;
    logic [15:0]            drop_cnt_o;

    modport master (
        output enable_i, broadcast_i, sel_i, data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, sel_err_o, drop_cnt_o
    );

    modport slave (
        input  enable_i, broadcast_i, sel_i, data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, sel_err_o, drop_cnt_o
    );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-N_CH stream demultiplexer with broadcast, a one-entry
// holding register per channel, and bad-select drop accounting.
module stream_demux #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    stream_demux_if.slave bus
);

    if (N_CH < 2 || N_CH > 16 || (1 << SEL_W) < N_CH) begin : g_bad_params
        $error("stream_demux: N_CH must be 2..16 and 2**SEL_W >= N_CH");
    end

    logic [N_CH*DATA_W-1:0] data_q;
    logic [N_CH-1:0]        valid_q;
    logic                   sel_err_q;
    logic [15:0]            drop_cnt_q;

    logic [N_CH-1:0] ch_free;
    logic            sel_ok;
    logic            sel_free;
    logic            ready;
    logic            accept;

    assign ch_free = ~valid_q | bus.ready_i;
    assign sel_ok  = int'(bus.sel_i) < N_CH;

    always_comb begin
        sel_free = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(bus.sel_i) == k) begin
                sel_free = ch_free[k];
            end
        end
    end

    // A bad select is always taken so it can be dropped and counted.
    always_comb begin
        ready = 1'b0;
        if (bus.enable_i) begin
            if (bus.broadcast_i) begin
                ready = &ch_free;
            end else if (!sel_ok) begin
                ready = 1'b1;
            end else begin
                ready = sel_free;
            end
        end
    end

    assign accept = bus.valid_i && ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q     <= '0;
            valid_q    <= '0;
            sel_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            sel_err_q <= accept && !bus.broadcast_i && !sel_ok;
            if (accept && !bus.broadcast_i && !sel_ok && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            // A load in the pop cycle wins, giving one word per cycle per channel.
            for (int k = 0; k < N_CH; k++) begin
                if (accept && (bus.broadcast_i || int'(bus.sel_i) == k)) begin
                    data_q[k*DATA_W +: DATA_W] <= bus.data_i;
                    valid_q[k]                 <= 1'b1;
                end else if (bus.ready_i[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.ready_o    = ready;
    assign bus.data_o     = data_q;
    assign bus.valid_o    = valid_q;
    assign bus.sel_err_o  = sel_err_q;
    assign bus.drop_cnt_o = drop_cnt_q;

    // Producer must hold a stalled word steady until it is taken.
    property p_hold_stalled;
        @(posedge clk_i) disable iff (rst_i)
        (bus.valid_i && !ready) |=>
            (!bus.valid_i || ($stable(bus.sel_i) && $stable(bus.broadcast_i) && $stable(bus.data_i)));
    endproperty
    a_hold_stalled: assert property (p_hold_stalled);

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a vector table on a 4-channel instance
// plus hand-written bad-select and reset sequences on a 3-channel instance.
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_demux_if #(.DATA_W(8), .N_CH(4), .SEL_W(2)) b4 ();
    stream_demux_if #(.DATA_W(8), .N_CH(3), .SEL_W(2)) b3 ();

    stream_demux #(.DATA_W(8), .N_CH(4), .SEL_W(2)) u4 (.clk_i(clk), .rst_i(rst), .bus(b4));
    stream_demux #(.DATA_W(8), .N_CH(3), .SEL_W(2)) u3 (.clk_i(clk), .rst_i(rst), .bus(b3));

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        bc;
        logic [1:0]  sel;
        logic [7:0]  din;
        logic        vin;
        logic [3:0]  rdy;
        logic        chk_rdy;
        logic        e_rdy;
        logic [3:0]  e_valid;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    task automatic add(input logic r, input logic en, input logic bc, input logic [1:0] sel,
                       input logic [7:0] din, input logic vin, input logic [3:0] rdy,
                       input logic chk, input logic e_rdy, input logic [3:0] e_valid,
                       input logic [31:0] e_data);
        vec_t v;
        v = '{rst: r, en: en, bc: bc, sel: sel, din: din, vin: vin, rdy: rdy,
              chk_rdy: chk, e_rdy: e_rdy, e_valid: e_valid, e_data: e_data};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        b4.enable_i = 1'b0; b4.broadcast_i = 1'b0; b4.sel_i = '0;
        b4.data_i = '0; b4.valid_i = 1'b0; b4.ready_i = '0;
        b3.enable_i = 1'b1; b3.broadcast_i = 1'b0; b3.sel_i = '0;
        b3.data_i = '0; b3.valid_i = 1'b0; b3.ready_i = '0;

        //   rst en bc sel  din    vin rdy      chk e_rdy e_valid  e_data
        add(1, 0, 0, 2'd0, 8'h00, 0, 4'b0000, 0, 0, 4'b0000, 32'h00000000);
        add(0, 1, 0, 2'd2, 8'hA5, 1, 4'b1111, 1, 1, 4'b0100, 32'h00A50000);
        add(0, 1, 0, 2'd2, 8'hA5, 0, 4'b1111, 1, 1, 4'b0000, 32'h00A50000);
        add(0, 1, 0, 2'd1, 8'h11, 1, 4'b1101, 1, 1, 4'b0010, 32'h00A51100);
        add(0, 1, 0, 2'd1, 8'h22, 1, 4'b1101, 1, 0, 4'b0010, 32'h00A51100);
        add(0, 1, 0, 2'd1, 8'h22, 1, 4'b1101, 1, 0, 4'b0010, 32'h00A51100);
        add(0, 1, 0, 2'd1, 8'h22, 1, 4'b1111, 1, 1, 4'b0010, 32'h00A52200);
        add(0, 1, 0, 2'd1, 8'h22, 0, 4'b1111, 1, 1, 4'b0000, 32'h00A52200);
        add(0, 1, 0, 2'd2, 8'h77, 1, 4'b1011, 1, 1, 4'b0100, 32'h00772200);
        add(0, 1, 1, 2'd2, 8'h3C, 1, 4'b1011, 1, 0, 4'b0100, 32'h00772200);
        add(0, 1, 1, 2'd2, 8'h3C, 1, 4'b1111, 1, 1, 4'b1111, 32'h3C3C3C3C);
        add(0, 1, 0, 2'd0, 8'h3C, 0, 4'b1111, 1, 1, 4'b0000, 32'h3C3C3C3C);
        add(0, 1, 0, 2'd0, 8'h5A, 1, 4'b0000, 1, 1, 4'b0001, 32'h3C3C3C5A);
        add(0, 0, 0, 2'd0, 8'h66, 1, 4'b0000, 1, 0, 4'b0001, 32'h3C3C3C5A);
        add(0, 0, 0, 2'd0, 8'h66, 1, 4'b0001, 1, 0, 4'b0000, 32'h3C3C3C5A);
        add(0, 0, 0, 2'd0, 8'h66, 0, 4'b0000, 1, 0, 4'b0000, 32'h3C3C3C5A);
        add(0, 1, 0, 2'd3, 8'h81, 1, 4'b1111, 1, 1, 4'b1000, 32'h813C3C5A);
        add(0, 1, 0, 2'd3, 8'h82, 1, 4'b1111, 1, 1, 4'b1000, 32'h823C3C5A);
        add(0, 1, 0, 2'd0, 8'h90, 1, 4'b0111, 1, 1, 4'b1001, 32'h823C3C90);
        add(0, 1, 0, 2'd3, 8'h93, 1, 4'b0111, 1, 0, 4'b1000, 32'h823C3C90);
        add(0, 1, 0, 2'd3, 8'h93, 0, 4'b1111, 1, 1, 4'b0000, 32'h823C3C90);
        add(1, 1, 1, 2'd0, 8'hC3, 1, 4'b1111, 1, 1, 4'b0000, 32'h00000000);

        foreach (vecs[i]) begin
            rst            = vecs[i].rst;
            b4.enable_i    = vecs[i].en;
            b4.broadcast_i = vecs[i].bc;
            b4.sel_i       = vecs[i].sel;
            b4.data_i      = vecs[i].din;
            b4.valid_i     = vecs[i].vin;
            b4.ready_i     = vecs[i].rdy;
            #1;
            if (vecs[i].chk_rdy) begin
                check($sformatf("v%0d ready_o", i), 32'(b4.ready_o), 32'(vecs[i].e_rdy));
            end
            step();
            check($sformatf("v%0d valid_o", i), 32'(b4.valid_o), 32'(vecs[i].e_valid));
            check($sformatf("v%0d data_o", i), b4.data_o, vecs[i].e_data);
            check($sformatf("v%0d sel_err_o", i), 32'(b4.sel_err_o), 32'd0);
        end
        rst = 1'b0;
        b4.valid_i = 1'b0;

        // Three bad-select words on the 3-channel instance.
        for (int i = 0; i < 3; i++) begin
            b3.broadcast_i = 1'b0; b3.sel_i = 2'd3; b3.data_i = 8'(i + 1);
            b3.valid_i = 1'b1; b3.ready_i = 3'b111;
            #1;
            check($sformatf("bad%0d ready_o", i), 32'(b3.ready_o), 32'd1);
            step();
            check($sformatf("bad%0d sel_err_o", i), 32'(b3.sel_err_o), 32'd1);
            check($sformatf("bad%0d valid_o", i), 32'(b3.valid_o), 32'd0);
            check($sformatf("bad%0d drop_cnt_o", i), 32'(b3.drop_cnt_o), 32'(i + 1));
        end

        // Highest legal channel still loads; error pulse ends.
        b3.sel_i = 2'd2; b3.data_i = 8'h4D; b3.valid_i = 1'b1; b3.ready_i = 3'b000;
        #1;
        check("ch2 ready_o", 32'(b3.ready_o), 32'd1);
        step();
        check("ch2 valid_o", 32'(b3.valid_o), 32'b100);
        check("ch2 data_o", 32'(b3.data_o), 32'h004D0000);
        check("ch2 sel_err_o", 32'(b3.sel_err_o), 32'd0);
        check("ch2 drop_cnt_o", 32'(b3.drop_cnt_o), 32'd3);

        // Reset coinciding with an accepted broadcast.
        rst = 1'b1;
        b3.broadcast_i = 1'b1; b3.data_i = 8'hE7; b3.valid_i = 1'b1; b3.ready_i = 3'b111;
        #1;
        check("rstbc ready_o", 32'(b3.ready_o), 32'd1);
        step();
        check("rstbc valid_o", 32'(b3.valid_o), 32'd0);
        check("rstbc data_o", 32'(b3.data_o), 32'd0);
        check("rstbc drop_cnt_o", 32'(b3.drop_cnt_o), 32'd0);
        check("rstbc sel_err_o", 32'(b3.sel_err_o), 32'd0);
        rst = 1'b0;

        // Broadcast ignores an out-of-range select.
        b3.sel_i = 2'd3;
        #1;
        check("bc3 ready_o", 32'(b3.ready_o), 32'd1);
        step();
        check("bc3 valid_o", 32'(b3.valid_o), 32'b111);
        check("bc3 data_o", 32'(b3.data_o), 32'h00E7E7E7);
        check("bc3 sel_err_o", 32'(b3.sel_err_o), 32'd0);
        check("bc3 drop_cnt_o", 32'(b3.drop_cnt_o), 32'd0);
        b3.valid_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised, registered successor to the team's 1-to-4 combinational demultiplexer.
- Routes a valid/ready input stream to one of N_CH output channels selected per word, or broadcasts it to all channels.
- Each output channel has a one-entry holding register, so outputs no longer latch combinationally.
- Sits between a single producer and N_CH independent consumers, for example engine lanes or port queues.

Parameters:
- DATA_W, 8: data width of input and of each output channel.
- N_CH, 4: number of output channels, 2..16.
- SEL_W, 2: select width. Must satisfy 2**SEL_W >= N_CH; an elaboration-time check fails otherwise.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- enable_i  in  1  when low, no input word is accepted and ready_o=0. Pending outputs still drain.
- broadcast_i  in  1  when high, the word goes to every channel and sel_i is ignored.
- sel_i  in  SEL_W  destination channel index.
- data_i  in  DATA_W  input data.
- valid_i  in  1  input word valid.
- ready_o  out  1  input word accepted this cycle when valid_i&&ready_o.
- data_o  out  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- valid_o  out  N_CH  per-channel output valid.
- ready_i  in  N_CH  per-channel consumer ready.
- sel_err_o  out  1  one-cycle pulse: an accepted word had sel_i >= N_CH.
- drop_cnt_o  out  16  count of words dropped for a bad select; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - valid_o=0, data_o=0, sel_err_o=0, drop_cnt_o=0.
  - Reset overrides every other event in the same cycle.
  - An in-flight word is lost; the producer must re-send it.
- Channel k is free when !valid_o[k] || ready_i[k].
- ready_o is combinational from enable_i, broadcast_i, sel_i, valid_o and ready_i. It never depends on valid_i.
  - enable_i=0: ready_o=0.
  - Broadcast: ready_o=1 only when all N_CH channels are free (all-or-nothing).
  - Unicast, sel_i<N_CH: ready_o = channel sel_i free.
  - Unicast, sel_i>=N_CH: ready_o=1, so a bad word is always accepted and dropped.
- Output pop: when valid_o[k]&&ready_i[k], the channel pops.
  - valid_o[k] clears next cycle unless it is reloaded in the same cycle.
  - data_o[k] keeps its last value after a pop; only valid_o changes.
- Load on accept (valid_i&&ready_o):
  - Unicast: data_o[sel_i]<=data_i and valid_o[sel_i]<=1 on the next edge. Latency is 1 cycle from input handshake to valid_o.
  - Broadcast: every channel is loaded and every valid_o is set.
  - Bad select: no channel is loaded. sel_err_o=1 for one cycle (registered). drop_cnt_o increments unless already 16'hFFFF.
- Simultaneous pop and load on the same channel:
  - The load wins; valid_o stays 1 and new data appears.
  - Full throughput is 1 word/cycle per channel while ready_i[k] is held high.
- The holding registers of non-selected channels are untouched by unicast loads.
- Input signals are sampled only on the handshake. data_i and sel_i may change freely when no handshake occurs.
- Producer requirement: sel_i, broadcast_i and data_i stay stable while valid_i=1 and ready_o=0. This is asserted in simulation only.
- drop_cnt_o has no clear other than rst_i.

Test Plan:
- Reset, then unicast data_i=8'hA5 with sel_i=2 and ready_i=4'b1111 -> valid_o=4'b0100 and data_o[2]=8'hA5 one cycle after the handshake; valid_o=0 the following cycle. The other channels hold 8'h00.
- Back-pressure: hold ready_i[1]=0. Send 8'h11 then 8'h22 to sel_i=1 -> the first is accepted. ready_o=0 while the second waits. Raise ready_i[1] -> 8'h22 loads in the pop cycle and valid_o[1] stays 1 with no bubble.
- Broadcast 8'h3C with ready_i=4'b1011 and channel 2 occupied -> ready_o=0. Free channel 2 -> all four channels show 8'h3C and valid_o=4'b1111 for one cycle.
- Bad select: N_CH=3, SEL_W=2, sel_i=3, three consecutive words -> ready_o=1. No valid_o is asserted. sel_err_o pulses each cycle and drop_cnt_o=3.
- enable_i=0 with valid_i=1 and channel 0 holding a word -> ready_o=0 and no new load. Channel 0 still drains when ready_i[0]=1.
- Assert rst_i in the same cycle as an accepted broadcast -> all valid_o=0 and data_o=0 next cycle, and drop_cnt_o=0.
